// File: rtl/snake_pkg.sv
// Shared constants, direction helpers and FSM state codes for the snake body
// writer and its neighbours.
package snake_pkg;

  localparam int COORD_W = 6;
  localparam int MAX_LEN = 100;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int BUS_W   = MAX_LEN * COORD_W;

  localparam logic [COORD_W-1:0] X_WALL = 6'd63;
  localparam logic [COORD_W-1:0] Y_WALL = 6'd47;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [1:0]         dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  // Opposite directions differ only in bit 0 (up/down, left/right).
  function automatic dir_t reverse_dir(input dir_t d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_body_writer_if.sv
// Game-side bus of the snake body writer: control pulses, collision query
// handshake and the packed body/status outputs.
interface snake_body_writer_if;
  import snake_pkg::*;

  logic              start;
  logic              step;
  dir_t              dir;
  logic              grow;
  logic              hit;
  coord_t            next_x;
  coord_t            next_y;
  logic [BUS_W-1:0]  snake_x;
  logic [BUS_W-1:0]  snake_y;
  logic [LEN_W-1:0]  length;
  logic              running;
  logic              dead;

  modport master (
    output start, step, dir, grow, hit,
    input  next_x, next_y, snake_x, snake_y, length, running, dead
  );

  modport slave (
    input  start, step, dir, grow, hit,
    output next_x, next_y, snake_x, snake_y, length, running, dead
  );

endinterface

// File: rtl/snake_next_head.sv
// Combinational candidate head: filters out 180-degree reversals and moves the
// head one cell, wrapping modulo 2^COORD_W (the query block treats walls as hits).
module snake_next_head
  import snake_pkg::*;
(
  input  coord_t head_x,
  input  coord_t head_y,
  input  dir_t   cur_dir,
  input  dir_t   dir,
  output coord_t next_x,
  output coord_t next_y,
  output dir_t   eff_dir
);

  always_comb begin
    eff_dir = (dir == reverse_dir(cur_dir)) ? cur_dir : dir;
    next_x  = head_x;
    next_y  = head_y;
    case (eff_dir)
      DIR_UP:    next_y = head_y - coord_t'(1);
      DIR_DOWN:  next_y = head_y + coord_t'(1);
      DIR_LEFT:  next_x = head_x - coord_t'(1);
      DIR_RIGHT: next_x = head_x + coord_t'(1);
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_body_writer.sv
// Owns the snake segment registers: advances, grows or kills the snake on each
// game step and publishes the body as packed x/y buses for query and render.
module snake_body_writer
  import snake_pkg::*;
#(
  parameter int INIT_X   = 32,
  parameter int INIT_Y   = 24,
  parameter int INIT_LEN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  snake_body_writer_if.slave bus
);

  logic [1:0]       state_q, state_d;
  coord_t           seg_x_q [MAX_LEN];
  coord_t           seg_x_d [MAX_LEN];
  coord_t           seg_y_q [MAX_LEN];
  coord_t           seg_y_d [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d, new_len;
  dir_t             cur_dir_q, cur_dir_d, eff_dir;
  logic             grow_pend_q, grow_pend_d;
  logic             dead_q, dead_d;
  coord_t           next_x, next_y;
  logic [BUS_W-1:0] snake_x_w, snake_y_w;

  // Initial body lies horizontally to the left of the head; parked slots are (0,0).
  function automatic coord_t init_x(input int k);
    return (k < INIT_LEN) ? coord_t'(INIT_X - k) : '0;
  endfunction

  function automatic coord_t init_y(input int k);
    return (k < INIT_LEN) ? coord_t'(INIT_Y) : '0;
  endfunction

  snake_next_head u_next_head (
    .head_x  (seg_x_q[0]),
    .head_y  (seg_y_q[0]),
    .cur_dir (cur_dir_q),
    .dir     (bus.dir),
    .next_x  (next_x),
    .next_y  (next_y),
    .eff_dir (eff_dir)
  );

  always_comb begin
    state_d     = state_q;
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    len_d       = len_q;
    cur_dir_d   = cur_dir_q;
    grow_pend_d = grow_pend_q | bus.grow;
    dead_d      = 1'b0;
    new_len     = len_q;
    if (bus.start) begin
      state_d = ST_RUN;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_d[k] = init_x(k);
        seg_y_d[k] = init_y(k);
      end
      len_d       = LEN_W'(INIT_LEN);
      cur_dir_d   = DIR_RIGHT;
      grow_pend_d = 1'b0;
    end else if ((state_q == ST_RUN) && bus.step) begin
      if (bus.hit) begin
        state_d = ST_DEAD;
        dead_d  = 1'b1;
      end else begin
        // A grow requested in this very cycle already counts for this move.
        if (grow_pend_d && (len_q < LEN_W'(MAX_LEN)))
          new_len = len_q + 1'b1;
        seg_x_d[0] = next_x;
        seg_y_d[0] = next_y;
        for (int i = 1; i < MAX_LEN; i++) begin
          if (LEN_W'(i) < new_len) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end else begin
            seg_x_d[i] = '0;
            seg_y_d[i] = '0;
          end
        end
        len_d       = new_len;
        cur_dir_d   = eff_dir;
        grow_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= init_x(k);
        seg_y_q[k] <= init_y(k);
      end
      len_q       <= LEN_W'(INIT_LEN);
      cur_dir_q   <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      len_q       <= len_d;
      cur_dir_q   <= cur_dir_d;
      grow_pend_q <= grow_pend_d;
      dead_q      <= dead_d;
    end
  end

  for (genvar j = 0; j < MAX_LEN; j++) begin : g_pack
    assign snake_x_w[(MAX_LEN-1-j)*COORD_W +: COORD_W] = seg_x_q[j];
    assign snake_y_w[(MAX_LEN-1-j)*COORD_W +: COORD_W] = seg_y_q[j];
  end

  assign bus.next_x  = next_x;
  assign bus.next_y  = next_y;
  assign bus.snake_x = snake_x_w;
  assign bus.snake_y = snake_y_w;
  assign bus.length  = len_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.dead    = dead_q;

endmodule

// File: tb/tb_snake_body_writer.sv
// Self-checking bench for snake_body_writer: directed table, max-length and
// reset corner sequences, then randomized play against a queue-based model.
module tb_snake_body_writer;
  import snake_pkg::*;

  localparam int INIT_X   = 32;
  localparam int INIT_Y   = 24;
  localparam int INIT_LEN = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snake_body_writer_if bus ();

  snake_body_writer #(
    .INIT_X   (INIT_X),
    .INIT_Y   (INIT_Y),
    .INIT_LEN (INIT_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: body as queues with the head at index 0.
  int m_x[$];
  int m_y[$];
  int m_dir;
  int m_pend;
  int m_run;
  int m_dead;

  typedef struct {
    bit   start;
    bit   step;
    bit   grow;
    bit   hit;
    dir_t dir;
    int   ex;
    int   ey;
    int   elen;
    bit   erun;
    bit   edead;
  } vec_t;

  vec_t tbl[16];

  task automatic checkOutput(input string name, input logic [BUS_W-1:0] act,
                             input logic [BUS_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit gr,
                               input bit h, input dir_t d);
    bus.start = st;
    bus.step  = sp;
    bus.grow  = gr;
    bus.hit   = h;
    bus.dir   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init(input int run);
    m_x.delete();
    m_y.delete();
    for (int k = 0; k < INIT_LEN; k++) begin
      m_x.push_back(INIT_X - k);
      m_y.push_back(INIT_Y);
    end
    m_dir  = 3;
    m_pend = 0;
    m_run  = run;
    m_dead = 0;
  endtask

  function automatic int model_eff(input int d);
    bit rev;
    rev = (d == 0 && m_dir == 1) || (d == 1 && m_dir == 0) ||
          (d == 2 && m_dir == 3) || (d == 3 && m_dir == 2);
    return rev ? m_dir : d;
  endfunction

  task automatic model_next(input int d, output int nx, output int ny);
    int e;
    e  = model_eff(d);
    nx = m_x[0];
    ny = m_y[0];
    if (e == 0) ny = ny - 1;
    if (e == 1) ny = ny + 1;
    if (e == 2) nx = nx - 1;
    if (e == 3) nx = nx + 1;
    nx = nx & 63;
    ny = ny & 63;
  endtask

  function automatic bit model_hit(input int nx, input int ny);
    bit h;
    h = (nx == 0) || (nx >= int'(X_WALL)) || (ny == 0) || (ny >= int'(Y_WALL));
    for (int j = 1; j < m_x.size(); j++)
      if (m_x[j] == nx && m_y[j] == ny) h = 1'b1;
    return h;
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit gr,
                            input bit h, input int d);
    int nx, ny;
    if (st) begin
      model_init(1);
      return;
    end
    m_dead = 0;
    if (gr) m_pend = 1;
    if (m_run != 0 && sp) begin
      if (h) begin
        m_run  = 0;
        m_dead = 1;
      end else begin
        model_next(d, nx, ny);
        m_dir = model_eff(d);
        m_x.push_front(nx);
        m_y.push_front(ny);
        if (!(m_pend != 0 && m_x.size() <= MAX_LEN)) begin
          void'(m_x.pop_back());
          void'(m_y.pop_back());
        end
        m_pend = 0;
      end
    end
  endtask

  function automatic logic [BUS_W-1:0] pack_x();
    logic [BUS_W-1:0] v;
    v = '0;
    for (int j = 0; j < m_x.size(); j++)
      v[(MAX_LEN-1-j)*COORD_W +: COORD_W] = coord_t'(m_x[j]);
    return v;
  endfunction

  function automatic logic [BUS_W-1:0] pack_y();
    logic [BUS_W-1:0] v;
    v = '0;
    for (int j = 0; j < m_y.size(); j++)
      v[(MAX_LEN-1-j)*COORD_W +: COORD_W] = coord_t'(m_y[j]);
    return v;
  endfunction

  task automatic check_model(input string tag);
    checkOutput({tag, " snake_x"}, bus.snake_x, pack_x());
    checkOutput({tag, " snake_y"}, bus.snake_y, pack_y());
    checkOutput({tag, " length"}, BUS_W'(bus.length), BUS_W'(m_x.size()));
    checkOutput({tag, " running"}, BUS_W'(bus.running), BUS_W'(m_run));
    checkOutput({tag, " dead"}, BUS_W'(bus.dead), BUS_W'(m_dead));
  endtask

  initial begin
    int nx, ny;
    bit st, sp, gr, h;
    dir_t d;

    tbl[0]  = '{1, 0, 0, 0, DIR_UP,    32, 24, 3, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, DIR_RIGHT, 33, 24, 3, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, DIR_RIGHT, 34, 24, 3, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, DIR_RIGHT, 35, 24, 3, 1, 0};
    tbl[4]  = '{0, 1, 0, 0, DIR_LEFT,  36, 24, 3, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, DIR_UP,    36, 24, 3, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, DIR_UP,    36, 24, 3, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, DIR_UP,    36, 23, 4, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, DIR_UP,    36, 22, 4, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, DIR_LEFT,  35, 22, 4, 1, 0};
    tbl[10] = '{0, 1, 0, 1, DIR_LEFT,  35, 22, 4, 0, 1};
    tbl[11] = '{0, 0, 0, 0, DIR_LEFT,  35, 22, 4, 0, 0};
    tbl[12] = '{0, 1, 0, 0, DIR_LEFT,  35, 22, 4, 0, 0};
    tbl[13] = '{1, 0, 0, 0, DIR_UP,    32, 24, 3, 1, 0};
    tbl[14] = '{1, 1, 0, 0, DIR_UP,    32, 24, 3, 1, 0};
    tbl[15] = '{0, 1, 0, 0, DIR_DOWN,  32, 25, 3, 1, 0};

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, DIR_UP);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_init(0);
    check_model("reset");
    checkOutput("reset next_x", BUS_W'(bus.next_x), BUS_W'(INIT_X));
    checkOutput("reset next_y", BUS_W'(bus.next_y), BUS_W'(INIT_Y - 1));

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].start, tbl[i].step, tbl[i].grow, tbl[i].hit, tbl[i].dir);
      tick();
      model_step(tbl[i].start, tbl[i].step, tbl[i].grow, tbl[i].hit, int'(tbl[i].dir));
      checkOutput($sformatf("vec%0d head_x", i), BUS_W'(bus.snake_x[BUS_W-1 -: COORD_W]), BUS_W'(tbl[i].ex));
      checkOutput($sformatf("vec%0d head_y", i), BUS_W'(bus.snake_y[BUS_W-1 -: COORD_W]), BUS_W'(tbl[i].ey));
      checkOutput($sformatf("vec%0d length", i), BUS_W'(bus.length), BUS_W'(tbl[i].elen));
      checkOutput($sformatf("vec%0d running", i), BUS_W'(bus.running), BUS_W'(tbl[i].erun));
      checkOutput($sformatf("vec%0d dead", i), BUS_W'(bus.dead), BUS_W'(tbl[i].edead));
      check_model($sformatf("vec%0d model", i));
    end

    // Reset asserted mid-cycle while a step is pending.
    applyStimulus(0, 1, 1, 0, DIR_RIGHT);
    #3 rst_n = 1'b0;
    #1;
    model_init(0);
    check_model("async reset");
    checkOutput("async reset next_x", BUS_W'(bus.next_x), BUS_W'(INIT_X + 1));
    tick();
    check_model("held reset");
    #4 rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0, DIR_RIGHT);
    tick();
    model_step(0, 1, 0, 0, 3);
    check_model("idle ignores step");

    // Grow to the maximum length, then one more grow must be absorbed.
    applyStimulus(1, 0, 0, 0, DIR_RIGHT);
    tick();
    model_step(1, 0, 0, 0, 3);
    for (int i = 0; i < 98; i++) begin
      d = dir_t'((i / 10) % 2 == 0 ? 3 : 1);
      applyStimulus(0, 1, 1, 0, d);
      tick();
      model_step(0, 1, 1, 0, int'(d));
      checkOutput($sformatf("maxlen len%0d", i), BUS_W'(bus.length), BUS_W'(m_x.size()));
    end
    checkOutput("maxlen length 100", BUS_W'(bus.length), BUS_W'(MAX_LEN));
    check_model("maxlen body");

    // Randomized play; hit is answered from the model's own view of the board.
    applyStimulus(1, 0, 0, 0, DIR_RIGHT);
    tick();
    model_step(1, 0, 0, 0, 3);
    for (int i = 0; i < 500; i++) begin
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 1) == 1);
      gr = ($urandom_range(0, 5) == 0);
      d  = dir_t'($urandom_range(0, 3));
      model_next(int'(d), nx, ny);
      h  = model_hit(nx, ny) || ($urandom_range(0, 29) == 0);
      applyStimulus(st, sp, gr, h, d);
      #1;
      checkOutput($sformatf("rnd%0d next_x", i), BUS_W'(bus.next_x), BUS_W'(nx));
      checkOutput($sformatf("rnd%0d next_y", i), BUS_W'(bus.next_y), BUS_W'(ny));
      tick();
      model_step(st, sp, gr, h, int'(d));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
